priority_encoder_pipe: RTL
==========================

Name: priority_encoder_pipe

Overview:
Parametrised, registered N-to-log2(N) priority encoder with valid/ready handshakes on both sides. It is the successor to the team's combinational 8-to-3 encoder. It adds a configurable input width, selectable priority direction, explicit no-bit and multi-bit flags, a set-bit count, and a one-deep output register with backpressure. It sits between request-vector producers (interrupt lines, arbiter requests) and a single consumer.

Parameters:
N, 8, input vector width; must be ≥2 and a power of two.
LSB_FIRST, 1, 1 = lowest set bit wins; 0 = highest set bit wins (fixed-priority mode only).
W, $clog2(N), encoded index width; derived localparam, not overridable.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_vec  input  N  request vector
in_valid  input  1  in_vec valid this cycle
in_ready  output  1  block can accept in_vec this cycle
out_idx  output  W  encoded index of the winning bit
out_onehot  output  N  one-hot of the winning bit; 0 when out_none=1
out_none  output  1  accepted vector was all zeros
out_multi  output  1  accepted vector had ≥2 bits set
out_cnt  output  W+1  number of set bits in the accepted vector
out_valid  output  1  output register holds a result
out_ready  input  1  consumer accepts the result

Behaviour:
- Single clock. Reset is synchronous and active-low.
- Reset: when rst_n=0 at a rising edge, these all load 0: out_valid, out_idx, out_onehot, out_none, out_multi, out_cnt, and the RR pointer. in_ready is held 0 combinationally while rst_n=0.
- in_ready = rst_n & (!out_valid | out_ready). This is combinational with no bubble, giving full throughput.
- Input transfer (acc) = in_valid & in_ready. Output transfer = out_valid & out_ready.
- Latency: exactly 1 cycle. A vector accepted at edge k is presented on the outputs at edge k with out_valid=1.
- On acc, all result fields load together. On output transfer without a new acc, out_valid <= 0 and the data fields hold their last value.
- If out_valid=1 and out_ready=0, the outputs stay stable and in_ready=0.
- Simultaneous output transfer and acc: the new result replaces the old one in the same edge, and out_valid stays 1.
- Zero vector: accepted normally. out_none=1, out_idx=0, out_onehot=0, out_multi=0, out_cnt=0.
- out_multi = (out_cnt ≥ 2).
- out_cnt is a full popcount from 0 to N. For example, N=8 with all bits set gives out_cnt=4'b1000.
- Fixed priority: LSB_FIRST=1 selects the smallest set index; LSB_FIRST=0 selects the largest.
- out_onehot is always the decode of out_idx when out_none=0.
- in_vec is sampled only on acc and ignored otherwise.
- Reset mid-stream: a pending result is discarded, nothing is emitted after reset, and the RR pointer returns to 0.

Optional Feature:
Macro: PRIORITY_ENCODER_PIPE_RR_EN.
- Defined:
  - A W-bit rotating pointer ptr selects the winner: the first set bit searching ascending from ptr, wrapping N-1→0.
  - LSB_FIRST is ignored.
  - On an acc with a nonzero vector, ptr <= (winner+1) mod N. On an acc with a zero vector, or when there is no acc, ptr holds.
  - out_none, out_multi and out_cnt are unchanged by this mode.
- Undefined: no pointer logic is synthesised and the block is purely fixed-priority.

Test Plan:
1. Reset and single-bit sweep (N=8, LSB_FIRST=1, out_ready=1):
   - Hold rst_n=0 for 2 cycles → all outputs 0 and in_ready=0.
   - Release, then drive 8'b00000001 through 8'b10000000, one per cycle → out_idx 0..7 one cycle after each, out_onehot equals the input, out_multi=0, out_cnt=1.
2. Boundary vectors:
   - 8'b00000000 → out_none=1, out_idx=0, out_cnt=0.
   - 8'b00000110 → out_idx=1, out_multi=1, out_cnt=2.
   - 8'hFF → out_idx=0, out_cnt=8.
   - Repeat with LSB_FIRST=0: 8'b00000110 → out_idx=2, and 8'hFF → out_idx=7.
3. Backpressure:
   - Accept 8'b00001000, then hold out_ready=0 for 3 cycles with in_valid=1 and in_vec=8'b00100000 → out_idx stays 3, out_valid=1, in_ready=0.
   - Raise out_ready → out_idx=3 transfers, the same edge loads 5, and out_valid stays 1.
4. Throughput: stream 16 back-to-back vectors with out_ready=1 → 16 results on consecutive cycles, in order, and in_ready never drops.
5. Mid-stream reset: pull rst_n=0 for one cycle while out_valid=1 and out_ready=0 → next cycle out_valid=0, and the held result is never transferred.
6. RR (macro defined): present 8'b10000001 repeatedly → out_idx 0,7,0,7…; then 8'b00000000 → ptr unchanged; then 8'b00010001 after a grant of 7 → out_idx=0, next 4.

Source files
------------

// File: rtl/priority_encoder_pipe.sv
// Registered N-to-log2(N) priority encoder with valid/ready on both sides and a one-deep output register.
// Define PRIORITY_ENCODER_PIPE_RR_EN to replace fixed priority with a rotating round-robin pointer.
module priority_encoder_pipe #(
  parameter int N         = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         in_vec,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [$clog2(N)-1:0] out_idx,
  output logic [N-1:0]         out_onehot,
  output logic                 out_none,
  output logic                 out_multi,
  output logic [$clog2(N):0]   out_cnt,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int W = $clog2(N);

  logic         acc;
  logic [W-1:0] win_idx;
  logic         win_none;
  logic [N-1:0] win_onehot;
  logic [W:0]   pop;

  // The slot is free when empty or being drained this same edge, so there is no bubble.
  assign in_ready = rst_n & (~out_valid | out_ready);
  assign acc      = in_valid & in_ready;
  assign win_none = ~|in_vec;

`ifdef PRIORITY_ENCODER_PIPE_RR_EN
  logic [W-1:0] ptr;
  logic [W-1:0] rr_pos;
  logic         found;

  // N is a power of two, so the W-bit add wraps N-1 -> 0 for free.
  always_comb begin
    win_idx = '0;
    rr_pos  = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      rr_pos = ptr + W'(k);
      if (!found && in_vec[rr_pos]) begin
        win_idx = rr_pos;
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      ptr <= '0;
    else if (acc && !win_none)
      ptr <= win_idx + W'(1);
  end
`else
  // NOTE: every variable written in always_comb gets a default first; otherwise a missed path infers a latch.
  always_comb begin
    win_idx = '0;
    if (LSB_FIRST) begin
      for (int i = N - 1; i >= 0; i--)
        if (in_vec[i]) win_idx = W'(i);
    end else begin
      for (int i = 0; i < N; i++)
        if (in_vec[i]) win_idx = W'(i);
    end
  end
`endif

  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++)
      pop = pop + (W+1)'(in_vec[i]);
  end

  assign win_onehot = win_none ? '0 : (N'(1) << win_idx);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_onehot <= '0;
      out_none   <= 1'b0;
      out_multi  <= 1'b0;
      out_cnt    <= '0;
    end else if (acc) begin
      out_valid  <= 1'b1;
      out_idx    <= win_idx;
      out_onehot <= win_onehot;
      out_none   <= win_none;
      out_multi  <= (pop > (W+1)'(1));
      out_cnt    <= pop;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule
